// File: rtl/quotient_collector.sv
// quotient_collector: show-ahead FIFO that collects quotients from a pipelined divider.
// Ports:
//   clock      - rising-edge clock for all state
//   reset_n    - asynchronous active-low reset
//   q_in       - quotient from the divider, valid when q_valid=1
//   q_valid    - divider result strobe
//   clear      - synchronous flush of contents and flags, overrides write/pop
//   dout       - oldest stored quotient (0 while empty)
//   dout_valid - FIFO is non-empty
//   dout_ready - consumer accepts dout this cycle
//   count      - occupancy 0..DEPTH
//   overflow   - sticky, set when a quotient was dropped on a full FIFO
//   total      - accepted writes since reset/clear, saturating at 65535
module quotient_collector #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [WIDTH-1:0]         q_in,
  input  logic                     q_valid,
  input  logic                     clear,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [15:0]              total
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] full_cnt = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic full, pop, push;
  assign full       = count == full_cnt;
  assign dout_valid = count != '0;
  assign pop        = dout_valid & dout_ready;
  // a pop on the same edge frees the slot, so a full FIFO can still accept
  assign push       = q_valid & (~full | pop);
  assign dout       = dout_valid ? mem[rd_ptr] : '0;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      total    <= '0;
    end else if (clear) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      total    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count    <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
      overflow <= overflow | (q_valid & full & ~pop);
      if (push && total != 16'hFFFF) total <= total + 1'b1;
    end
  end
  // storage is deliberately left unreset; dout is masked while empty
  always_ff @(posedge clock) begin
    if (push && !clear) mem[wr_ptr] <= q_in;
  end
endmodule

// File: tb/tb_quotient_collector.sv
// tb_quotient_collector: scoreboard bench for quotient_collector (WIDTH=8, DEPTH=8).
module tb_quotient_collector;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] q_in = '0;
  logic       q_valid = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready = 1'b0;
  logic [3:0] count;
  logic       overflow;
  logic [15:0] total;
  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  quotient_collector #(.WIDTH(8), .DEPTH(8)) dut (
    .clock(clock), .reset_n(reset_n), .q_in(q_in), .q_valid(q_valid), .clear(clear),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .count(count), .overflow(overflow), .total(total)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [7:0] v, input bit accepted);
    q_in = v;
    q_valid = 1'b1;
    if (accepted) exp_q.push_back(v);
    tick();
    q_valid = 1'b0;
  endtask

  // monitor: every pop the DUT will take on the coming edge is compared here
  always @(negedge clock) begin
    if (dout_valid && dout_ready) begin
      if (exp_q.size() == 0) chk("unexpected_pop", int'(dout), -1);
      else chk("pop_data", int'(dout), int'(exp_q.pop_front()));
    end
  end

  initial begin
    #2;
    chk("rst_count", count, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_total", total, 0);
    chk("rst_dout", dout, 0);
    #10 reset_n = 1'b1;
    tick();
    // burst: 765,3315,5865,9180 / 63
    wr(8'd12, 1); wr(8'd52, 1); wr(8'd93, 1); wr(8'd145, 1);
    chk("burst_count", count, 4);
    chk("burst_dout", dout, 12);
    dout_ready = 1'b1;
    repeat (4) tick();
    dout_ready = 1'b0;
    chk("burst_empty_valid", dout_valid, 0);
    chk("burst_total", total, 4);
    clear = 1'b1; tick(); clear = 1'b0;
    // overflow
    for (int i = 1; i <= 10; i++) wr(8'(i), i <= 8);
    chk("ovf_count", count, 8);
    chk("ovf_flag", overflow, 1);
    chk("ovf_total", total, 8);
    dout_ready = 1'b1;
    repeat (8) tick();
    dout_ready = 1'b0;
    chk("ovf_drained", count, 0);
    chk("ovf_sticky", overflow, 1);
    clear = 1'b1; tick(); clear = 1'b0;
    // full with concurrent write and pop
    for (int i = 1; i <= 8; i++) wr(8'(i), 1);
    chk("full_count", count, 8);
    dout_ready = 1'b1;
    wr(8'd9, 1);
    dout_ready = 1'b0;
    chk("fwp_count", count, 8);
    chk("fwp_overflow", overflow, 0);
    chk("fwp_total", total, 9);
    dout_ready = 1'b1;
    repeat (8) tick();
    dout_ready = 1'b0;
    chk("fwp_drained", count, 0);
    clear = 1'b1; tick(); clear = 1'b0;
    // streaming
    dout_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wr(8'(100 + i), 1);
      chk("stream_count", count, 1);
    end
    tick();
    dout_ready = 1'b0;
    chk("stream_empty", count, 0);
    chk("stream_total", total, 20);
    // clear priority
    clear = 1'b1; tick(); clear = 1'b0;
    for (int i = 1; i <= 9; i++) wr(8'(i), i <= 8);
    dout_ready = 1'b1;
    repeat (3) tick();
    dout_ready = 1'b0;
    chk("clr_pre_count", count, 5);
    chk("clr_pre_overflow", overflow, 1);
    clear = 1'b1;
    q_in = 8'd77;
    q_valid = 1'b1;
    tick();
    clear = 1'b0;
    q_valid = 1'b0;
    exp_q.delete();
    chk("clr_count", count, 0);
    chk("clr_overflow", overflow, 0);
    chk("clr_total", total, 0);
    chk("clr_valid", dout_valid, 0);
    // async reset between edges
    wr(8'd21, 1); wr(8'd22, 1); wr(8'd23, 1);
    chk("ar_pre_count", count, 3);
    #2 reset_n = 1'b0;
    #1;
    exp_q.delete();
    chk("ar_count", count, 0);
    chk("ar_valid", dout_valid, 0);
    chk("ar_total", total, 0);
    chk("ar_dout", dout, 0);
    tick();
    #2 reset_n = 1'b1;
    tick();
    wr(8'd7, 1);
    chk("ar_post_dout", dout, 7);
    chk("ar_post_count", count, 1);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    chk("final_count", count, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
